// File: rtl/wb_slave_mem_pkg.sv
// Shared Wishbone definitions for the memory slave: bus widths, FSM
// state encoding and the saturating counter helper.
package wb_slave_mem_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    ERR,
    DONE
  } wb_sl_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B3 classic bus bundle between one master and the memory slave.
interface wb_slave_mem_if;
  import wb_slave_mem_pkg::*;

  logic [WB_ADDR_WIDTH-1:0] wb_adr_i;
  logic [WB_DATA_WIDTH-1:0] wb_dat_i;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_i;
  logic                     wb_we_i;
  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic [WB_DATA_WIDTH-1:0] wb_dat_o;
  logic                     wb_ack_o;
  logic                     wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_slave_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read
// port. The read register doubles as the slave's data output, so it is
// reset and can be cleared when an access is rejected.
module wb_slave_mem_array
  import wb_slave_mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr,
  input  logic [MEM_AW-1:0]        idx,
  input  logic [WB_DATA_WIDTH-1:0] wdata,
  input  logic [WB_SEL_WIDTH-1:0]  sel,
  output logic [WB_DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** MEM_AW;

  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; a plain always block so the backdoor loader can share the array.
  always @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < WB_SEL_WIDTH; b++) begin
        if (sel[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read of the full word; cleared on reset and on rejected accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

  task mem_load(input logic [MEM_AW-1:0] load_idx, input logic [WB_DATA_WIDTH-1:0] load_data);
    mem[load_idx] <= load_data;
  endtask

  task mem_peek(input logic [MEM_AW-1:0] peek_idx, output logic [WB_DATA_WIDTH-1:0] peek_data);
    peek_data = mem[peek_idx];
  endtask

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 classic-cycle memory slave. Each access runs
// IDLE -> [WAIT] -> ACK/ERR -> DONE -> IDLE, so the master's stale strobe
// during the ack cycle is never taken as a new request.
module wb_slave_mem
  import wb_slave_mem_pkg::*;
#(
  parameter int          MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  wb_slave_mem_if.slave  bus,
  output logic [15:0]    wr_cnt_o,
  output logic [15:0]    rd_cnt_o,
  output logic [15:0]    err_cnt_o
);

  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_sl_state_e state;

  logic [3:0]               wait_cnt;
  logic [MEM_AW-1:0]        lat_idx;
  logic [WB_DATA_WIDTH-1:0] lat_dat;
  logic [WB_SEL_WIDTH-1:0]  lat_sel;
  logic                     lat_we;
  logic                     lat_bad;
  logic                     ack_q;
  logic                     err_q;

  logic                     req;
  logic                     req_hit;
  logic                     req_bad;
  logic [MEM_AW-1:0]        req_idx;
  logic                     go_ack;
  logic                     go_err;
  logic [MEM_AW-1:0]        eff_idx;
  logic [WB_DATA_WIDTH-1:0] eff_dat;
  logic [WB_SEL_WIDTH-1:0]  eff_sel;
  logic                     eff_we;
  logic                     unused_adr_lsb;

  assign req            = bus.wb_cyc_i & bus.wb_stb_i;
  assign req_hit        = (bus.wb_adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign req_bad        = !req_hit | (bus.wb_sel_i == '0);
  assign req_idx        = bus.wb_adr_i[MEM_AW+1:2];
  assign unused_adr_lsb = ^bus.wb_adr_i[1:0];

  // Decide whether this edge enters ACK or ERR; a zero-wait access uses the live bus fields.
  always_comb begin
    go_ack  = 1'b0;
    go_err  = 1'b0;
    eff_idx = lat_idx;
    eff_dat = lat_dat;
    eff_sel = lat_sel;
    eff_we  = lat_we;
    case (state)
      IDLE: begin
        eff_idx = req_idx;
        eff_dat = bus.wb_dat_i;
        eff_sel = bus.wb_sel_i;
        eff_we  = bus.wb_we_i;
        if (req && NO_WAIT) begin
          go_ack = !req_bad;
          go_err = req_bad;
        end
      end
      WAIT: begin
        if (req && (wait_cnt == 4'd0)) begin
          go_ack = !lat_bad;
          go_err = lat_bad;
        end
      end
      default: ;
    endcase
  end

  wb_slave_mem_array #(
    .MEM_AW (MEM_AW)
  ) u_array (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .wr_en (go_ack & eff_we),
    .rd_en (go_ack & !eff_we),
    .clr   (go_err),
    .idx   (eff_idx),
    .wdata (eff_dat),
    .sel   (eff_sel),
    .rdata (bus.wb_dat_o)
  );

  // Access sequencer with registered ack/err and saturating scoreboard counters.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_idx   <= '0;
      lat_dat   <= '0;
      lat_sel   <= '0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_cnt_o  <= 16'd0;
      rd_cnt_o  <= 16'd0;
      err_cnt_o <= 16'd0;
    end else begin
      ack_q <= go_ack;
      err_q <= go_err;
      if (go_ack) begin
        if (eff_we) wr_cnt_o <= sat_inc(wr_cnt_o);
        else        rd_cnt_o <= sat_inc(rd_cnt_o);
      end
      if (go_err) err_cnt_o <= sat_inc(err_cnt_o);

      case (state)
        IDLE: begin
          if (req) begin
            lat_idx <= req_idx;
            lat_dat <= bus.wb_dat_i;
            lat_sel <= bus.wb_sel_i;
            lat_we  <= bus.wb_we_i;
            lat_bad <= req_bad;
            if (NO_WAIT) begin
              state <= req_bad ? ERR : ACK;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= lat_bad ? ERR : ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK:     state <= DONE;
        ERR:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: three instances with 0, 3 and 5 wait
// states share one clock and reset and are driven one at a time.
module tb_wb_slave_mem;
  import wb_slave_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0;
  logic [2:0]  m_cyc = '0;
  logic [2:0]  m_stb = '0;

  logic [2:0]  ack_v;
  logic [2:0]  err_v;
  logic [31:0] dat_v [3];
  logic [15:0] wr_cnt [3];
  logic [15:0] rd_cnt [3];
  logic [15:0] err_cnt [3];

  int checks = 0;
  int errors = 0;
  int err3_pulses = 0;
  int overlap_n = 0;

  wb_slave_mem_if bus [3] ();

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].wb_adr_i = m_adr;
    assign bus[g].wb_dat_i = m_dat;
    assign bus[g].wb_sel_i = m_sel;
    assign bus[g].wb_we_i  = m_we;
    assign bus[g].wb_cyc_i = m_cyc[g];
    assign bus[g].wb_stb_i = m_stb[g];
    assign ack_v[g] = bus[g].wb_ack_o;
    assign err_v[g] = bus[g].wb_err_o;
    assign dat_v[g] = bus[g].wb_dat_o;
  end

  wb_slave_mem #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus[0]),
    .wr_cnt_o(wr_cnt[0]), .rd_cnt_o(rd_cnt[0]), .err_cnt_o(err_cnt[0]));
  wb_slave_mem #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus[1]),
    .wr_cnt_o(wr_cnt[1]), .rd_cnt_o(rd_cnt[1]), .err_cnt_o(err_cnt[1]));
  wb_slave_mem #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(5)) u_ws5 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus[2]),
    .wr_cnt_o(wr_cnt[2]), .rd_cnt_o(rd_cnt[2]), .err_cnt_o(err_cnt[2]));

  // Watch for error pulses on the 3-wait instance and ack/err overlap anywhere.
  always @(negedge clk) begin
    if (err_v[1]) err3_pulses++;
    if ((ack_v & err_v) != 3'b000) overlap_n++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One bus access on instance d; returns termination, data and cycles until ack/err.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] dt, input logic [3:0] s,
                               output logic got_ack, output logic got_err,
                               output logic [31:0] rd, output int cyc_n);
    repeat (2) @(negedge clk);
    m_we = w; m_adr = a; m_dat = dt; m_sel = s;
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    got_ack = 1'b0; got_err = 1'b0; rd = '0; cyc_n = 0;
    while (!(got_ack || got_err) && cyc_n < 40) begin
      @(negedge clk);
      cyc_n++;
      got_ack = ack_v[d];
      got_err = err_v[d];
      rd = dat_v[d];
    end
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
    @(negedge clk);
    checkOutput("term_one_cycle", {30'b0, ack_v[d], err_v[d]}, 32'd0);
  endtask

  logic        a_ack, a_err;
  logic [31:0] a_rd, peek;
  int          a_n, seen;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", {31'b0, ack_v[0]}, 32'd0);
    checkOutput("rst_err", {31'b0, err_v[0]}, 32'd0);
    checkOutput("rst_dat", dat_v[0], 32'd0);
    checkOutput("rst_wrcnt", {16'b0, wr_cnt[0]}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait write then read
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws0_wr_ack", {31'b0, a_ack}, 32'd1);
    checkOutput("ws0_wr_lat", a_n, 32'd1);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws0_rd_ack", {31'b0, a_ack}, 32'd1);
    checkOutput("ws0_rd_lat", a_n, 32'd1);
    checkOutput("ws0_rd_dat", a_rd, 32'hDEADBEEF);
    checkOutput("ws0_wrcnt1", {16'b0, wr_cnt[0]}, 32'd1);
    checkOutput("ws0_rdcnt1", {16'b0, rd_cnt[0]}, 32'd1);

    // Byte-lane write over a preloaded word
    u_ws0.u_array.mem_load(10'd8, 32'h11223344);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, a_ack, a_err, a_rd, a_n);
    checkOutput("lane_wr_ack", {31'b0, a_ack}, 32'd1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'b0001, a_ack, a_err, a_rd, a_n);
    checkOutput("lane_rd_dat", a_rd, 32'h11BB33DD);

    // Out-of-window address and empty byte select both terminate with err
    u_ws0.u_array.mem_load(10'd0, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 32'h0001_0000, 32'h12345678, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("miss_err", {30'b0, a_ack, a_err}, 32'd1);
    checkOutput("miss_dat0", a_rd, 32'd0);
    u_ws0.u_array.mem_peek(10'd0, peek);
    checkOutput("miss_nowrite", peek, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 32'h10, 32'h0, 4'h0, a_ack, a_err, a_rd, a_n);
    checkOutput("sel0_err", {30'b0, a_ack, a_err}, 32'd1);
    u_ws0.u_array.mem_peek(10'd4, peek);
    checkOutput("sel0_nowrite", peek, 32'hDEADBEEF);
    checkOutput("errcnt2", {16'b0, err_cnt[0]}, 32'd2);
    checkOutput("wrcnt_after_err", {16'b0, wr_cnt[0]}, 32'd2);

    // Three wait states: ack lands four cycles after the request edge
    applyStimulus(1, 1'b1, 32'h40, 32'h01020304, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws3_wr_ack", {30'b0, a_ack, a_err}, 32'd2);
    checkOutput("ws3_wr_lat", a_n, 32'd4);
    applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws3_rd_lat", a_n, 32'd4);
    checkOutput("ws3_rd_dat", a_rd, 32'h01020304);

    // Strobe dropped during the wait window aborts the access
    u_ws5.u_array.mem_load(10'd12, 32'h55AA55AA);
    repeat (2) @(negedge clk);
    m_we = 1'b1; m_adr = 32'h30; m_dat = 32'hFFFFFFFF; m_sel = 4'hF;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    repeat (2) @(negedge clk);
    m_stb[2] = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_v[2] || err_v[2]) seen++;
    end
    m_cyc[2] = 1'b0;
    checkOutput("abort_no_term", seen, 32'd0);
    u_ws5.u_array.mem_peek(10'd12, peek);
    checkOutput("abort_nowrite", peek, 32'h55AA55AA);
    checkOutput("abort_cnts", {wr_cnt[2], err_cnt[2]}, 32'd0);
    applyStimulus(2, 1'b1, 32'h30, 32'h0BADCAFE, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws5_wr_lat", a_n, 32'd6);
    applyStimulus(2, 1'b0, 32'h30, 32'h0, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("ws5_rd_dat", a_rd, 32'h0BADCAFE);

    // Reset asserted in the middle of a wait window
    u_ws5.u_array.mem_load(10'd13, 32'h0);
    repeat (2) @(negedge clk);
    m_we = 1'b1; m_adr = 32'h34; m_dat = 32'h13579BDF; m_sel = 4'hF;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ackerr", {30'b0, ack_v[2], err_v[2]}, 32'd0);
    checkOutput("midrst_cnts", {wr_cnt[2], rd_cnt[2]}, 32'd0);
    checkOutput("midrst_dat", dat_v[2], 32'd0);
    checkOutput("midrst_state", {29'b0, u_ws5.state}, {29'b0, IDLE});
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    u_ws5.u_array.mem_peek(10'd13, peek);
    checkOutput("midrst_nowrite", peek, 32'h0);
    applyStimulus(2, 1'b1, 32'h34, 32'h2468ACE0, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("postrst_wr_ack", {30'b0, a_ack, a_err}, 32'd2);
    applyStimulus(2, 1'b0, 32'h34, 32'h0, 4'hF, a_ack, a_err, a_rd, a_n);
    checkOutput("postrst_rd_dat", a_rd, 32'h2468ACE0);
    checkOutput("postrst_cnts", {wr_cnt[2], rd_cnt[2]}, 32'h0001_0001);

    checkOutput("ws3_no_err", err3_pulses, 32'd0);
    checkOutput("ack_err_overlap", overlap_n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
- Wishbone B3 classic-cycle slave (responder) with a byte-enabled word memory.
- It is the far end of the Wishbone bus, complementing the master driver. It models the system memory that the ethmac DMA master port (m_wb_*) reads TX frames from and writes RX frames to.
- Responses are registered, with programmable wait states, an error response for bad accesses, and saturating access counters for scoreboarding.

Parameters:
- MEM_AW, 10, memory address width in 32-bit words; depth = 2**MEM_AW.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**MEM_AW.
- WAIT_STATES, 0, extra cycles inserted before every ack/err; legal range 0..15.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n selects dat[8n+7:8n].
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wr_cnt_o  out  16  completed writes, saturating.
- rd_cnt_o  out  16  completed reads, saturating.
- err_cnt_o  out  16  error terminations, saturating.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, all counters 0. Memory contents are not reset.
- Request: cyc_i & stb_i sampled high at a rising edge while in IDLE.
- Decode:
  - hit = (adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]).
  - Word index = adr_i[MEM_AW+1:2]; adr_i[1:0] ignored.
  - bad = !hit | (sel_i == 4'b0).
- FSM states:
  - IDLE: on request, go to WAIT if WAIT_STATES>0, else to ACK when !bad, else to ERR. Latch adr, dat, sel, we, bad.
  - WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to ACK or ERR.
  - ACK: wb_ack_o=1 for exactly one cycle, then go to DONE.
  - ERR: wb_err_o=1 for exactly one cycle, then go to DONE.
  - DONE: one idle turnaround cycle, then IDLE. The master's stale stb is never re-sampled.
- Latency: request edge N gives ack/err high in cycle N+1+WAIT_STATES. Back-to-back throughput is one access per WAIT_STATES+3 cycles.
- Write commit:
  - Performed at the edge entering ACK. Only bytes with sel=1 are updated, using the latched data.
  - Bytes with sel=0 keep their old value. ERR never writes.
- Read data:
  - wb_dat_o is registered at the edge entering ACK from mem[index]; all 4 bytes are returned regardless of sel.
  - wb_dat_o holds its last value otherwise; it is 0 after ERR.
- Abort: cyc_i or stb_i low at any edge while in WAIT returns the FSM to IDLE. No ack, no write, no counter change.
- Counters:
  - wr_cnt_o/rd_cnt_o increment on entering ACK according to latched we.
  - err_cnt_o increments on entering ERR.
  - Each saturates at 16'hFFFF.
- Invariants: wb_ack_o and wb_err_o are never high together, and neither is high outside ACK/ERR.
- Reset asserted mid-WAIT: outputs clear immediately; a pending write is dropped.

Decomposition:
- Shared wishbone package:
  - WB_ADDR_WIDTH=32, WB_DATA_WIDTH=32, WB_SEL_WIDTH=4.
  - State enum wb_sl_state_e {IDLE, WAIT, ACK, ERR, DONE}.
  - Saturation max constant.
- Sub-module wb_slave_mem_array:
  - Single-port synchronous RAM, 2**MEM_AW x 32, per-byte write enables, registered read.
  - Also offers hierarchical backdoor tasks mem_load(idx, data) and mem_peek(idx) for the bench.

Test Plan:
- WAIT_STATES=0, write adr 32'h10, dat 32'hDEADBEEF, sel 4'hF, then read 32'h10 -> ack one cycle after each request; read returns 32'hDEADBEEF; wr_cnt=1, rd_cnt=1.
- Byte lanes: preload 32'h11223344 at 32'h20, write 32'hAABBCCDD with sel 4'b0101 -> readback 32'h11BB33DD.
- WAIT_STATES=3, request at edge N -> ack high in cycle N+4 only; err never asserted.
- Address 32'h0001_0000 (out of window), and separately sel 4'h0 -> err_o pulses once each; no memory change; err_cnt=2; dat_o=0.
- stb_i dropped during WAIT (WAIT_STATES=5) -> no ack/err; target word unchanged; counters unchanged; next request serviced normally.
- Assert wb_rst_n_i mid-WAIT -> ack/err/counters 0 asynchronously; FSM in IDLE; subsequent write/read pair passes.
